// File: rtl/hpc_pulse_launcher.sv
// hpc_pulse_launcher: queues single-cycle event requests in the src_clkA domain
// and hands them to the hpc pulse synchronizer one at a time. A new sinput
// pulse is launched only after the previous handshake has finished, either
// because busy rose and fell or because busy never rose in time.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | waiting for a queued event while busy is low
//   PULSE | sinput high for exactly this one cycle
//   ACK   | waiting up to RISE_TO cycles for busy to rise
//   BUSY  | transfer in flight, waiting for busy to fall
//   GAP   | GAP_CYC enforced quiet cycles before returning to IDLE
module hpc_pulse_launcher #(
    parameter int CNT_W   = 4,
    parameter int GAP_CYC = 2,
    parameter int RISE_TO = 4
) (
    input  logic             src_clkA,
    input  logic             rstA,
    input  logic             ev_in,
    input  logic             clr,
    input  logic             busy,
    output logic             sinput,
    output logic [CNT_W-1:0] pending,
    output logic             full,
    output logic             ovf,
    output logic [7:0]       drop_cnt,
    output logic             to_err
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PULSE = 3'd1,
        ACK   = 3'd2,
        BUSY  = 3'd3,
        GAP   = 3'd4
    } stateT;

    localparam int TO_W  = (RISE_TO < 2) ? 1 : $clog2(RISE_TO);
    localparam int GAP_W = (GAP_CYC < 2) ? 1 : $clog2(GAP_CYC);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(RISE_TO - 1);
    // GAP is never entered when GAP_CYC is 0, so its terminal value is moot then.
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
    localparam stateT AFTER_XFER = (GAP_CYC > 0) ? GAP : IDLE;

    stateT             state;
    stateT             nextState;
    logic [TO_W-1:0]   toCnt;
    logic [TO_W-1:0]   toCntNext;
    logic [GAP_W-1:0]  gapCnt;
    logic [GAP_W-1:0]  gapCntNext;
    logic              launch;
    logic              toHit;
    logic              incOnly;
    logic              decOnly;
    logic              drop;

    assign full    = (pending == {CNT_W{1'b1}});
    assign incOnly = ev_in & ~launch;
    assign decOnly = launch & ~ev_in;
    assign drop    = incOnly & full;

    // State register, handshake timers and the registered launch pulse.
    always_ff @(posedge src_clkA) begin
        if (!rstA) begin
            state  <= IDLE;
            toCnt  <= '0;
            gapCnt <= '0;
            sinput <= 1'b0;
        end else begin
            state  <= nextState;
            toCnt  <= toCntNext;
            gapCnt <= gapCntNext;
            sinput <= launch;
        end
    end

    // Next-state logic: launch decision, rise timeout and post-transfer gap.
    always_comb begin
        nextState  = state;
        toCntNext  = toCnt;
        gapCntNext = gapCnt;
        launch     = 1'b0;
        toHit      = 1'b0;
        unique case (state)
            IDLE: begin
                if ((pending != '0) && !busy) begin
                    nextState = PULSE;
                    launch    = 1'b1;
                end
            end
            PULSE: begin
                nextState = ACK;
                toCntNext = '0;
            end
            ACK: begin
                if (busy) begin
                    nextState = BUSY;
                end else if (toCnt == TO_LAST) begin
                    toHit      = 1'b1;
                    nextState  = AFTER_XFER;
                    gapCntNext = '0;
                end else begin
                    toCntNext = toCnt + 1'b1;
                end
            end
            BUSY: begin
                if (!busy) begin
                    nextState  = AFTER_XFER;
                    gapCntNext = '0;
                end
            end
            GAP: begin
                if (gapCnt == GAP_LAST) begin
                    nextState = IDLE;
                end else begin
                    gapCntNext = gapCnt + 1'b1;
                end
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // Pending count plus sticky status; a new drop or timeout beats clr.
    always_ff @(posedge src_clkA) begin
        if (!rstA) begin
            pending  <= '0;
            ovf      <= 1'b0;
            drop_cnt <= 8'd0;
            to_err   <= 1'b0;
        end else begin
            if (incOnly && !full) begin
                pending <= pending + 1'b1;
            end else if (decOnly) begin
                pending <= pending - 1'b1;
            end

            if (drop) begin
                ovf <= 1'b1;
                if (clr) begin
                    drop_cnt <= 8'd1;
                end else if (drop_cnt != 8'hFF) begin
                    drop_cnt <= drop_cnt + 8'd1;
                end
            end else if (clr) begin
                ovf      <= 1'b0;
                drop_cnt <= 8'd0;
            end

            if (toHit) begin
                to_err <= 1'b1;
            end else if (clr) begin
                to_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_hpc_pulse_launcher.sv
// Testbench for hpc_pulse_launcher: directed scenarios followed by random
// traffic, every cycle compared against a transaction-level reference model.
module tb_hpc_pulse_launcher;

    localparam int CNT_W    = 4;
    localparam int GAP_CYC  = 2;
    localparam int RISE_TO  = 4;
    localparam int PEND_MAX = (1 << CNT_W) - 1;

    logic             src_clkA = 1'b0;
    logic             rstA;
    logic             ev_in;
    logic             clr;
    logic             busy;
    logic             sinput;
    logic [CNT_W-1:0] pending;
    logic             full;
    logic             ovf;
    logic [7:0]       drop_cnt;
    logic             to_err;

    hpc_pulse_launcher #(
        .CNT_W   (CNT_W),
        .GAP_CYC (GAP_CYC),
        .RISE_TO (RISE_TO)
    ) dut (
        .src_clkA (src_clkA),
        .rstA     (rstA),
        .ev_in    (ev_in),
        .clr      (clr),
        .busy     (busy),
        .sinput   (sinput),
        .pending  (pending),
        .full     (full),
        .ovf      (ovf),
        .drop_cnt (drop_cnt),
        .to_err   (to_err)
    );

    // Free-running source clock.
    always #5 src_clkA = ~src_clkA;

    int nCompared   = 0;
    int nMismatched = 0;
    int cyc         = 0;

    // Reference model: queue depth, sticky flags and handshake timing in cycles.
    int mPending  = 0;
    bit mSinput   = 0;
    bit mOvf      = 0;
    int mDrop     = 0;
    bit mToErr    = 0;
    bit mWaiting  = 0;
    bit mRise     = 0;
    int mPulseCyc = 0;
    int mIdleFrom = 0;

    // Behavioural hpc responder and observation logs.
    int busyMode  = 1;
    int rDly      = 2;
    int rHold     = 6;
    int respStart = -100;
    int respEnd   = -100;
    bit prevSinput = 0;
    bit prevToErr  = 0;
    int toRiseCyc  = -1;
    int pulseLog[$];
    int evCyc;

    task automatic checkEq(input string tag, input int obs, input int exp);
        nCompared++;
        if (obs != exp) begin
            nMismatched++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic modelStep();
        bit launch;
        bit toHit;
        bit drop;
        if (!rstA) begin
            mPending = 0; mSinput = 0; mOvf = 0; mDrop = 0; mToErr = 0;
            mWaiting = 0; mRise = 0; mIdleFrom = 0;
            return;
        end
        launch = !mWaiting && (cyc >= mIdleFrom) && (mPending > 0) && !busy;
        toHit  = 0;
        if (mWaiting && (cyc > mPulseCyc)) begin
            if (!mRise) begin
                if (busy) begin
                    mRise = 1;
                end else if (cyc == mPulseCyc + RISE_TO) begin
                    toHit     = 1;
                    mWaiting  = 0;
                    mIdleFrom = cyc + 1 + GAP_CYC;
                end
            end else if (!busy) begin
                mWaiting  = 0;
                mIdleFrom = cyc + 1 + GAP_CYC;
            end
        end
        drop = ev_in && !launch && (mPending == PEND_MAX);
        if (ev_in && !launch && !drop) mPending++;
        else if (launch && !ev_in) mPending--;
        if (drop) begin
            mOvf  = 1;
            mDrop = clr ? 1 : ((mDrop < 255) ? mDrop + 1 : 255);
        end else if (clr) begin
            mOvf  = 0;
            mDrop = 0;
        end
        if (toHit) mToErr = 1;
        else if (clr) mToErr = 0;
        mSinput = launch;
        if (launch) begin
            mWaiting  = 1;
            mRise     = 0;
            mPulseCyc = cyc + 1;
        end
    endtask

    // One clock cycle: compare at the falling edge, advance model, drive busy.
    task automatic tick();
        @(negedge src_clkA);
        checkEq("sinput",   int'(sinput),   int'(mSinput));
        checkEq("pending",  int'(pending),  mPending);
        checkEq("full",     int'(full),     int'(mPending == PEND_MAX));
        checkEq("ovf",      int'(ovf),      int'(mOvf));
        checkEq("drop_cnt", int'(drop_cnt), mDrop);
        checkEq("to_err",   int'(to_err),   int'(mToErr));
        checkEq("sinput_back_to_back", int'(sinput && prevSinput), 0);
        if (sinput === 1'b1) pulseLog.push_back(cyc);
        if ((to_err === 1'b1) && !prevToErr && (toRiseCyc < 0)) toRiseCyc = cyc;
        prevSinput = (sinput === 1'b1);
        prevToErr  = (to_err === 1'b1);
        modelStep();
        @(posedge src_clkA);
        #1;
        cyc++;
        if (mSinput) begin
            respStart = cyc + rDly;
            respEnd   = respStart + rHold - 1;
        end
        case (busyMode)
            0:       busy = (cyc >= respStart) && (cyc <= respEnd);
            1:       busy = 1'b1;
            2:       busy = 1'b0;
            default: busy = 1'($urandom_range(0, 1));
        endcase
    endtask

    initial begin
        rstA = 1'b0; ev_in = 1'b1; clr = 1'b0; busy = 1'b1; busyMode = 1;
        @(posedge src_clkA);
        #1;

        // Reset held with ev_in and busy high.
        repeat (3) tick();
        checkEq("rst_sinput",  int'(sinput),   0);
        checkEq("rst_pending", int'(pending),  0);
        checkEq("rst_ovf",     int'(ovf),      0);
        checkEq("rst_drop",    int'(drop_cnt), 0);
        checkEq("rst_to_err",  int'(to_err),   0);
        rstA = 1'b1;
        tick();
        ev_in = 1'b0;
        checkEq("rst_release_pending", int'(pending), 1);
        busyMode = 0; busy = 1'b0; rDly = 2; rHold = 6;
        repeat (20) tick();

        // Single event into an idle launcher.
        pulseLog.delete();
        evCyc = cyc;
        ev_in = 1'b1; tick(); ev_in = 1'b0;
        repeat (25) tick();
        checkEq("single_pulse_count", pulseLog.size(), 1);
        if (pulseLog.size() >= 1) checkEq("single_latency", pulseLog[0] - evCyc, 2);

        // Event arriving on the edge that enters PULSE with pending=1.
        ev_in = 1'b1; tick(); tick(); ev_in = 1'b0;
        checkEq("simul_sinput",  int'(sinput),  1);
        checkEq("simul_pending", int'(pending), 1);
        repeat (30) tick();

        // Burst of five events.
        pulseLog.delete();
        ev_in = 1'b1; repeat (5) tick(); ev_in = 1'b0;
        repeat (80) tick();
        checkEq("burst_pulse_count", pulseLog.size(), 5);
        for (int i = 1; i < pulseLog.size(); i++)
            checkEq("burst_spacing", pulseLog[i] - pulseLog[i-1], 1 + 2 + 6 + GAP_CYC + 1);
        checkEq("burst_end_pending", int'(pending), 0);

        // Overflow: first event launches, then busy sticks high.
        busyMode = 2; busy = 1'b0;
        ev_in = 1'b1; tick(); tick();
        busyMode = 1; busy = 1'b1;
        repeat (18) tick();
        ev_in = 1'b0; tick();
        checkEq("ovf_pending", int'(pending),  PEND_MAX);
        checkEq("ovf_full",    int'(full),     1);
        checkEq("ovf_drops",   int'(drop_cnt), 4);
        checkEq("ovf_flag",    int'(ovf),      1);
        clr = 1'b1; tick(); clr = 1'b0;
        checkEq("clr_ovf",     int'(ovf),      0);
        checkEq("clr_drops",   int'(drop_cnt), 0);
        checkEq("clr_pending", int'(pending),  PEND_MAX);
        clr = 1'b1; ev_in = 1'b1; tick(); clr = 1'b0; ev_in = 1'b0;
        checkEq("clr_drop_ovf",   int'(ovf),      1);
        checkEq("clr_drop_count", int'(drop_cnt), 1);
        clr = 1'b1; tick(); clr = 1'b0;
        busyMode = 0; busy = 1'b0; rHold = 3; respStart = -100; respEnd = -100;
        repeat (200) tick();
        checkEq("drain_pending", int'(pending), 0);

        // Timeout with busy tied low; two queued events.
        busyMode = 2; busy = 1'b0;
        pulseLog.delete(); toRiseCyc = -1;
        ev_in = 1'b1; tick(); tick(); ev_in = 1'b0;
        repeat (20) tick();
        checkEq("to_pulse_count", pulseLog.size(), 2);
        if (pulseLog.size() >= 2) begin
            checkEq("to_err_delay", toRiseCyc - pulseLog[0], RISE_TO + 1);
            checkEq("to_spacing", pulseLog[1] - pulseLog[0], 1 + RISE_TO + GAP_CYC + 1);
        end
        clr = 1'b1; tick(); clr = 1'b0;
        checkEq("to_clr", int'(to_err), 0);

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            if ((n % 200) == 0) begin
                case ($urandom_range(0, 5))
                    0:       busyMode = 1;
                    1:       busyMode = 2;
                    2:       busyMode = 3;
                    default: busyMode = 0;
                endcase
            end
            rDly  = $urandom_range(1, RISE_TO + 2);
            rHold = $urandom_range(1, 8);
            ev_in = ($urandom_range(0, 99) < 40);
            clr   = ($urandom_range(0, 99) < 3);
            rstA  = ($urandom_range(0, 299) != 0);
            tick();
        end
        rstA = 1'b1; ev_in = 1'b0; clr = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/hpc_pulse_launcher.md
# hpc_pulse_launcher

Source-domain (src_clkA) event queue that feeds the `hpc` handshake pulse synchronizer. It accepts single-cycle event requests at any rate and counts them as pending. It issues them to `hpc` as single-cycle `sinput` pulses, one at a time, launching each only after the previous handshake has completed and `busy` has returned low. Overflow, drop and handshake-timeout conditions are reported as status.

## Interface
- `CNT_W`, 4: pending-counter width; max pending = 2^CNT_W-1
- `GAP_CYC`, 2: idle cycles enforced after `busy` falls, before the next launch (0 allowed)
- `RISE_TO`, 4: cycles to wait for `busy` to rise after a pulse before declaring timeout (>=1)

Ports:
- `src_clkA` in 1: source clock; the only clock in the block
- `rstA` in 1: reset, synchronous, active-low
- `ev_in` in 1: event request; every high cycle is one event
- `clr` in 1: clears `ovf`, `to_err` and `drop_cnt` (not `pending`)
- `busy` in 1: from `hpc`, src_clkA domain; high while a transfer is in flight
- `sinput` out 1: registered single-cycle pulse to `hpc`
- `pending` out CNT_W: events queued and not yet launched
- `full` out 1: `pending` == 2^CNT_W-1 (combinational from `pending` register)
- `ovf` out 1: sticky; an event was dropped
- `drop_cnt` out 8: dropped events, saturating at 255
- `to_err` out 1: sticky; `busy` failed to rise within `RISE_TO` cycles of a pulse

## Operation
- Reset (`rstA`=0 at an edge): state IDLE; `sinput`, `pending`, `ovf`, `drop_cnt`, `to_err` = 0; internal counters = 0. Queued events are discarded. Reset overrides `clr` and `ev_in`.
- Pending arithmetic, per edge:
  - inc = `ev_in`; dec = FSM entering PULSE.
  - inc & dec: unchanged.
  - inc only: +1 if not full; otherwise the event is dropped, `ovf`<=1 and `drop_cnt`+1 (saturating at 255).
  - dec only: -1.
  - No wrap in either direction.
- `clr`: at the same edge, `ovf`<=0, `to_err`<=0, `drop_cnt`<=0. If a drop or timeout occurs in the same cycle, the set wins: the flag is 1, and `drop_cnt` is 1.
- FSM states:
  - IDLE: if `pending`>0 and `busy`=0 -> PULSE (`sinput`<=1, pending decremented). Otherwise stay.
  - PULSE (1 cycle, `sinput`=1) -> ACK; `sinput`<=0; timeout counter <=0.
  - ACK: if `busy`=1 -> BUSY. Else, if the counter reaches RISE_TO-1 -> `to_err`<=1 and go to GAP (or IDLE if GAP_CYC=0). Otherwise counter+1.
  - BUSY: if `busy`=0 -> GAP (or IDLE if GAP_CYC=0).
  - GAP: count GAP_CYC cycles, then -> IDLE.
- `sinput` is never high in two consecutive cycles. It is never asserted while `busy`=1 is sampled in IDLE.

## Timing
- Latency, empty queue with `busy`=0 and FSM in IDLE:
  - `ev_in` high in cycle k -> `pending`=1 in cycle k+1.
  - `sinput`=1 and `pending`=0 in cycle k+2.
- Back-to-back launch spacing = 1 (PULSE) + ACK cycles + BUSY cycles + GAP_CYC + 1 (IDLE check).
- `busy` already high in ACK's first cycle -> BUSY at the next edge.
- Timeout spacing = 1 + RISE_TO + GAP_CYC + 1.
- `full` and `pending` update on the same edge.

## Test plan
- Reset: hold `rstA`=0 for 3 edges with `ev_in`=1 and `busy`=1 -> all outputs 0. Release -> `pending` counts from 0.
- Single event, with `busy` modelled as rising 2 cycles after `sinput` and high for 6 cycles:
  - `ev_in` at cycle 10 -> `sinput` only in cycle 12.
  - `pending` goes 1 -> 0.
  - No second pulse.
- Burst: `ev_in` high for 5 cycles -> `pending` peaks at 4 or 5. Exactly 5 `sinput` pulses, each spaced >= 2+6+GAP_CYC+1 cycles apart. `pending` ends at 0.
- Overflow, CNT_W=4, `busy` stuck high: 20 events -> `pending`=15, `full`=1, `drop_cnt`=4, `ovf`=1. `clr` -> `ovf`=0 and `drop_cnt`=0, while `pending` stays 15.
- Timeout, `busy` tied 0: 1 event -> one pulse, `to_err`=1 exactly RISE_TO cycles after the ACK entry. The next pulse (if queued) follows after GAP_CYC+1 more cycles.
- Simultaneous events:
  - `ev_in`=1 on the edge entering PULSE with `pending`=1 -> `pending` stays 1.
  - `clr` and a drop in the same cycle -> `ovf`=1, `drop_cnt`=1.
